// File: rtl/tour_cmd_sched.sv
// Knight's tour command scheduler: passes UART commands through when idle and,
// once a tour starts, issues each move as a vertical leg then a horizontal leg.
module tour_cmd_sched #(
  parameter logic [4:0] LAST_MOVE = 5'd23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  input  logic        tour_go,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_err
);

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

  state_t      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic        tour_err_q, tour_err_d;

  logic [7:0]  v_hdg, h_hdg;
  logic [2:0]  v_cnt, h_cnt;
  logic        move_ok;
  logic [15:0] leg_v, leg_h;

  always_comb begin
    v_hdg = HDG_N;
    v_cnt = 3'd0;
    h_hdg = HDG_N;
    h_cnt = 3'd0;
    case (move)
      8'h01: begin v_hdg = HDG_N; v_cnt = 3'd2; h_hdg = HDG_E; h_cnt = 3'd1; end
      8'h02: begin v_hdg = HDG_N; v_cnt = 3'd2; h_hdg = HDG_W; h_cnt = 3'd1; end
      8'h04: begin v_hdg = HDG_N; v_cnt = 3'd1; h_hdg = HDG_W; h_cnt = 3'd2; end
      8'h08: begin v_hdg = HDG_S; v_cnt = 3'd1; h_hdg = HDG_W; h_cnt = 3'd2; end
      8'h10: begin v_hdg = HDG_S; v_cnt = 3'd2; h_hdg = HDG_W; h_cnt = 3'd1; end
      8'h20: begin v_hdg = HDG_S; v_cnt = 3'd2; h_hdg = HDG_E; h_cnt = 3'd1; end
      8'h40: begin v_hdg = HDG_S; v_cnt = 3'd1; h_hdg = HDG_E; h_cnt = 3'd2; end
      8'h80: begin v_hdg = HDG_N; v_cnt = 3'd1; h_hdg = HDG_E; h_cnt = 3'd2; end
      default: ;
    endcase
  end

  assign move_ok = $onehot(move);
  assign leg_v   = {4'h4, v_hdg, 1'b0, v_cnt};
  assign leg_h   = {4'h5, h_hdg, 1'b0, h_cnt};

  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    tour_err_d       = 1'b0;
    cmd              = leg_v;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = 8'h5A;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'hA5;
        if (tour_go) begin
          mv_indx_d = '0;
          state_d   = VERT;
        end
      end
      VERT: begin
        // A bad move code is never offered to cmd_proc; the tour aborts instead.
        cmd_rdy = move_ok;
        if (!move_ok) begin
          tour_err_d = 1'b1;
          state_d    = IDLE;
        end else if (clr_cmd_rdy) begin
          state_d = HOLD_V;
        end
      end
      HOLD_V: begin
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = leg_h;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_H;
      end
      HOLD_H: begin
        cmd = leg_h;
        if (mv_indx_q == LAST_MOVE) resp = 8'hA5;
        if (send_resp) begin
          if (mv_indx_q == LAST_MOVE) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= '0;
      tour_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      tour_err_q <= tour_err_d;
    end
  end

  assign mv_indx  = mv_indx_q;
  assign tour_err = tour_err_q;

endmodule

// File: doc/tour_cmd_sched.md
# tour_cmd_sched

Command scheduler between the UART command path and `cmd_proc` in `KnightsTour`. When idle it passes remote commands straight through. On `tour_go` it takes ownership of `cmd_proc` and walks the 24 solved moves from `TourLogic`. Each knight L-move becomes two sequenced commands: a vertical leg with a plain move, then a horizontal leg with a fanfare move. Each leg waits for `cmd_proc` to accept it and to report completion before the next is issued.

## Interface
- `LAST_MOVE`, default 5'd23: index of the final move in the tour.
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous active-low reset.
- `cmd_UART` input 16: command from the UART wrapper.
- `cmd_rdy_UART` input 1: `cmd_UART` is valid.
- `clr_cmd_rdy_UART` output 1: consumes the UART command.
- `tour_go` input 1: one-cycle pulse that starts the tour.
- `move` input 8: one-hot move code for `mv_indx`, supplied by `TourLogic`.
- `mv_indx` output 5: index of the move being executed.
- `cmd` output 16: command to `cmd_proc`.
- `cmd_rdy` output 1: `cmd` is valid.
- `clr_cmd_rdy` input 1: `cmd_proc` accepted `cmd`.
- `send_resp` input 1: `cmd_proc` finished the command.
- `resp` output 8: response byte sent to the remote.
- `tour_err` output 1: one-cycle pulse when `move` is not one-hot.

## Operation
- **Command format:** `cmd[15:12]` is the opcode (4 = move, 5 = move with fanfare), `cmd[11:4]` is the heading, `cmd[3]` is 0, `cmd[2:0]` is the square count.
- **Headings:** N = 8'h00, S = 8'h7F, W = 8'h3F, E = 8'hBF.
- **Move decode:** leg V is vertical with opcode 4; leg H is horizontal with opcode 5.
  - bit0 (+1,+2): V = N2, H = E1.
  - bit1 (−1,+2): V = N2, H = W1.
  - bit2 (−2,+1): V = N1, H = W2.
  - bit3 (−2,−1): V = S1, H = W2.
  - bit4 (−1,−2): V = S2, H = W1.
  - bit5 (+1,−2): V = S2, H = E1.
  - bit6 (+2,−1): V = S1, H = E2.
  - bit7 (+2,+1): V = N1, H = E2.
- **States:** IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`, `clr_cmd_rdy_UART` = `clr_cmd_rdy`.
    - `tour_go`: `mv_indx` ← 0, go to VERT.
  - VERT: `cmd` = leg V, `cmd_rdy` = 1.
    - If `move` is not one-hot (zero bits or more than one bit set), pulse `tour_err` and go to IDLE.
    - Otherwise, on `clr_cmd_rdy` go to HOLD_V.
  - HOLD_V: `cmd_rdy` = 0. On `send_resp` go to HORZ.
  - HORZ: `cmd` = leg H, `cmd_rdy` = 1. On `clr_cmd_rdy` go to HOLD_H.
  - HOLD_H: `cmd_rdy` = 0. On `send_resp`:
    - if `mv_indx` == `LAST_MOVE`, go to IDLE;
    - otherwise `mv_indx` ← `mv_indx` + 1 and go to VERT.
- **`resp`:**
  - 8'h5A in every non-IDLE state, except during HOLD_H when `mv_indx` == `LAST_MOVE`.
  - 8'hA5 during that final HOLD_H and in IDLE.
  - Net effect: intermediate legs are acknowledged with 5A and tour completion with A5.
- **UART during tour:** `clr_cmd_rdy_UART` is forced to 0 outside IDLE. A pending UART command stays pending and is passed through on return to IDLE.
- **Ignored events:**
  - `tour_go` outside IDLE.
  - `send_resp` in VERT or HORZ.
  - `clr_cmd_rdy` in HOLD_V or HOLD_H.
- **Width:** `mv_indx` is 5 bits and never exceeds `LAST_MOVE`; there is no wrap.

## Timing
- **Reset values:** state = IDLE, `mv_indx` = 0, `tour_err` = 0. Reset is synchronous: `rst_n` low at an edge forces these values mid-operation, on the same edge.
- **Output timing:**
  - `cmd`, `cmd_rdy` and `resp` are combinational from state, `move` and the UART inputs.
  - `tour_err` is registered.
- **Latency from `tour_go`:** sampled at edge N; `cmd_rdy` is high with leg V of move 0 from edge N+1.
- **Acknowledge handshakes:**
  - `cmd_rdy` stays high until `clr_cmd_rdy` is sampled.
  - `clr_cmd_rdy` and `send_resp` may arrive in the same cycle at VERT or HORZ; only the acknowledge takes effect.
  - A `send_resp` landing in that same cycle is dropped.
- **Index update:** `mv_indx` updates on the HOLD_H→VERT edge. `move` must be valid on the next cycle, because `TourLogic` has combinational read.
- **Per-move cost:** minimum 4 cycles plus `cmd_proc` execution time.
- **`tour_err`:** high exactly one cycle, on the cycle after VERT is evaluated with a bad `move`.

## Test plan
- **Pass-through:** IDLE with `cmd_UART` = 16'h2000, `cmd_rdy_UART` = 1 → `cmd` = 2000, `cmd_rdy` = 1; `clr_cmd_rdy` pulse → `clr_cmd_rdy_UART` pulse in the same cycle; `resp` = A5.
- **Single move:** `tour_go` with `move` = 8'h01 → `cmd` = 16'h4002 with `cmd_rdy`.
  - ack → `cmd_rdy` = 0.
  - `send_resp` → `cmd` = 16'h5BF1.
  - ack plus `send_resp` → `mv_indx` = 1, `resp` = 5A.
- **Full tour:** a 24-entry move table cycling through all 8 codes → 48 commands, each matching the decode list.
  - `mv_indx` runs 0..23, then state returns to IDLE.
  - `resp` = A5 at the final `send_resp`.
- **Bad move code:** `move` = 8'h00, then 8'h03 at index 5 → `tour_err` pulse, state returns to IDLE, `mv_indx` holds 5, no `cmd_rdy` for that move.
- **Contention:** `cmd_rdy_UART` is raised mid-tour → `clr_cmd_rdy_UART` stays 0 throughout the tour. After the tour ends, the UART command appears on `cmd` in IDLE. A second `tour_go` mid-tour is ignored.
- **Mid-tour reset:** `rst_n` low in HOLD_V at `mv_indx` 7 → IDLE, `mv_indx` = 0 and `cmd_rdy` follows `cmd_rdy_UART` from the next cycle.
